// File: rtl/btn_event_ctrl.sv
// Button event controller: turns debounced button levels into press / long / release
// events and serves them to a single consumer in round-robin order.
module btn_event_ctrl #(
  parameter int NUM_BTN     = 4,
  parameter int LONG_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_level,
  input  logic                       evt_ready,
  input  logic                       ovf_clr,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_btn,
  output logic [1:0]                 evt_code,
  output logic [NUM_BTN-1:0]         ovf
);

  localparam int BTN_W = $clog2(NUM_BTN);
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);

  logic [NUM_BTN-1:0]            prev_q, prev_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]            press_q, press_d, long_q, long_d, rel_q, rel_d;
  logic [NUM_BTN-1:0]            ovf_q, ovf_d;
  logic [BTN_W-1:0]              last_q, last_d;
  logic                          valid_q, valid_d;
  logic [BTN_W-1:0]              btn_q, btn_d;
  logic [1:0]                    code_q, code_d;

  logic [NUM_BTN-1:0] rise, fall, long_det, any_pend;
  logic [NUM_BTN-1:0] clr_press, clr_long, clr_rel, ovf_set;
  logic               load, found;
  int                 sel, idx;

  always_comb begin
    prev_d   = btn_level;
    rise     = btn_level & ~prev_q;
    fall     = ~btn_level & prev_q;
    long_det = '0;
    cnt_d    = cnt_q;
    // cnt_q counts consecutive high cycles seen so far, saturating at LONG_CYCLES
    for (int i = 0; i < NUM_BTN; i++) begin
      long_det[i] = btn_level[i] & prev_q[i] & (cnt_q[i] == CNT_W'(LONG_CYCLES - 1));
      if (!btn_level[i]) begin
        cnt_d[i] = '0;
      end else if (rise[i]) begin
        cnt_d[i] = CNT_W'(1);
      end else if (cnt_q[i] != CNT_W'(LONG_CYCLES)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    any_pend = press_q | long_q | rel_q;
    found    = 1'b0;
    sel      = 0;
    idx      = 0;
    for (int off = 1; off <= NUM_BTN; off++) begin
      idx = (int'(last_q) + off) % NUM_BTN;
      if (!found && any_pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    load      = ~valid_q | evt_ready;
    clr_press = '0;
    clr_long  = '0;
    clr_rel   = '0;
    valid_d   = valid_q;
    btn_d     = btn_q;
    code_d    = code_q;
    last_d    = last_q;
    if (load) begin
      if (found) begin
        valid_d = 1'b1;
        btn_d   = BTN_W'(sel);
        last_d  = BTN_W'(sel);
        if (press_q[sel]) begin
          code_d         = 2'b01;
          clr_press[sel] = 1'b1;
        end else if (long_q[sel]) begin
          code_d        = 2'b10;
          clr_long[sel] = 1'b1;
        end else begin
          code_d       = 2'b11;
          clr_rel[sel] = 1'b1;
        end
      end else begin
        valid_d = 1'b0;
        btn_d   = '0;
        code_d  = 2'b00;
      end
    end

    // A detection landing on a flag being consumed this cycle simply re-arms it
    press_d = (press_q & ~clr_press) | rise;
    long_d  = (long_q & ~clr_long) | long_det;
    rel_d   = (rel_q & ~clr_rel) | fall;
    ovf_set = (rise & press_q & ~clr_press) | (long_det & long_q & ~clr_long)
            | (fall & rel_q & ~clr_rel);
    ovf_d   = ovf_clr ? ovf_set : (ovf_q | ovf_set);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      press_q <= '0;
      long_q  <= '0;
      rel_q   <= '0;
      ovf_q   <= '0;
      last_q  <= BTN_W'(NUM_BTN - 1);
      valid_q <= 1'b0;
      btn_q   <= '0;
      code_q  <= 2'b00;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      long_q  <= long_d;
      rel_q   <= rel_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      btn_q   <= btn_d;
      code_q  <= code_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_btn   = btn_q;
  assign evt_code  = code_q;
  assign ovf       = ovf_q;

endmodule
